vram_arbiter: RTL and testbench



---
 rtl/vram_arbiter_pkg.sv | 34 +++
 rtl/vram_port_reg.sv | 45 ++++
 rtl/vram_arbiter.sv | 83 ++++++++
 tb/tb_vram_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared constants for the VRAM arbiter: FSM encoding, default
// screen geometry and VRAM widths, plus the scan-phase next-state rule.
package vram_arbiter_pkg;

    localparam logic [1:0] ST_SYNC   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_VBLANK = 2'd2;

    localparam int H_W_DEF    = 800;
    localparam int V_H_DEF    = 480;
    localparam int ADDR_W_DEF = 17;
    localparam int DATA_W_DEF = 12;

    function automatic logic [1:0] next_state(
        input logic [1:0] st,
        input logic       line_start,
        input logic       at_top,
        input logic       at_vb
    );
        logic [1:0] nx;
        nx = st;
        // Phase changes only happen on the first pixel of a line
        if (line_start) begin
            case (st)
                ST_SYNC:   if (at_top) nx = ST_ACTIVE;
                ST_ACTIVE: if (at_vb)  nx = ST_VBLANK;
                ST_VBLANK: if (at_top) nx = ST_ACTIVE;
                default:   nx = ST_SYNC;
            endcase
        end
        return nx;
    endfunction

endpackage

// File: rtl/vram_port_reg.sv
// Registered VRAM command port: read beats write, idle cycles hold
// address/data; rd_valid tracks the read through port and RAM latency.
module vram_port_reg #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 12
) (
    input  logic              pix_clk,
    input  logic              pix_rstn,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_fire,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              rd_valid
);

    logic rd_pipe;

    always_ff @(posedge pix_clk or negedge pix_rstn) begin
        if (!pix_rstn) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_pipe   <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            rd_pipe  <= rd_req;
            rd_valid <= rd_pipe;
            mem_en   <= rd_req | wr_fire;
            mem_we   <= ~rd_req & wr_fire;
            if (rd_req) begin
                mem_addr <= rd_addr;
            end else if (wr_fire) begin
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads always win, game-logic
// writes fill hblank/idle slots and own the port during vblank.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int H_W    = H_W_DEF,
    parameter int V_H    = V_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              pix_clk,
    input  logic              pix_rstn,
    input  logic [15:0]       sx,
    input  logic [15:0]       sy,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              frame_tick,
    output logic              in_vblank
);

    logic [1:0] state;
    logic [1:0] state_nx;
    logic       line_start;
    logic       at_top;
    logic       at_vb;
    logic       in_hblank;
    logic       wr_fire;

    assign line_start = (sx == 16'd0);
    assign at_top     = (sy == 16'd0);
    assign at_vb      = (sy == 16'(V_H));
    assign in_hblank  = (sx >= 16'(H_W));

    always_comb begin
        state_nx = next_state(state, line_start, at_top, at_vb);
    end

    always_ff @(posedge pix_clk or negedge pix_rstn) begin
        if (!pix_rstn) begin
            state      <= ST_SYNC;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nx;
            frame_tick <= (state == ST_ACTIVE) && line_start && at_vb;
        end
    end

    assign in_vblank = (state == ST_VBLANK);

    // SYNC grants nothing: the writer waits for a clean frame start
    assign wr_ready = ~rd_req &
                      ((state == ST_VBLANK) ||
                       ((state == ST_ACTIVE) && in_hblank));
    assign wr_fire  = wr_valid & wr_ready;

    vram_port_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port (
        .pix_clk   (pix_clk),
        .pix_rstn  (pix_rstn),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .wr_fire   (wr_fire),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .rd_valid  (rd_valid)
    );

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: scripted scan positions, a VRAM model and
// queued expectations for the port, read data and grant decisions.
module tb_vram_arbiter;

    localparam int AW    = 17;
    localparam int DW    = 12;
    localparam int HW    = 800;
    localparam int VH    = 480;
    localparam int H_TOT = 810;

    typedef struct {
        logic          en;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } mop_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_t;

    logic          pix_clk;
    logic          pix_rstn;
    logic [15:0]   sx;
    logic [15:0]   sy;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          frame_tick;
    logic          in_vblank;

    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] vram   [0:(1<<AW)-1];
    logic [DW-1:0] shadow [0:(1<<AW)-1];

    mop_t mq[$];
    rd_t  rq[$];

    int   n_chk;
    int   n_fail;
    int   cyc;
    int   m_st;
    logic m_tick;
    logic m_acc;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata;
    int   acc_cnt;
    int   n_tick;
    int   first_x;
    int   first_y;
    logic wr_rand;
    int   wr_seq;

    vram_arbiter #(
        .H_W    (HW),
        .V_H    (VH),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .pix_clk    (pix_clk),
        .pix_rstn   (pix_rstn),
        .sx         (sx),
        .sy         (sy),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .frame_tick (frame_tick),
        .in_vblank  (in_vblank)
    );

    initial begin
        pix_clk = 1'b0;
        forever #5 pix_clk = ~pix_clk;
    end

    // One-cycle-latency VRAM primitive
    always @(posedge pix_clk) begin
        if (mem_en) begin
            if (mem_we) vram[mem_addr] <= mem_wdata;
            else        mem_rdata <= vram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic monitor();
        mop_t e;
        rd_t  r;
        logic ev;
        if (frame_tick === 1'b1) n_tick++;
        check("frame_tick", 32'(frame_tick), 32'(m_tick));
        check("in_vblank", 32'(in_vblank), 32'(m_st == 2));
        if (mq.size() > 0) begin
            e = mq.pop_front();
            check("mem_en", 32'(mem_en), 32'(e.en));
            check("mem_we", 32'(mem_we), 32'(e.we));
            check("mem_addr", 32'(mem_addr), 32'(e.addr));
            check("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
            if (e.en && e.we) shadow[e.addr] = e.wdata;
        end else begin
            check("mq_empty", 32'(mq.size()), 32'd1);
        end
        ev = (rq.size() > 0) && (rq[0].due == cyc);
        check("rd_valid", 32'(rd_valid), 32'(ev));
        if (ev) begin
            r = rq.pop_front();
            check("rdata", 32'(mem_rdata), 32'(r.data));
        end
    endtask

    task automatic cycle();
        mop_t e;
        logic exp_wr;
        monitor();
        #1;
        exp_wr = !rd_req && (m_st == 2 || (m_st == 1 && int'(sx) >= HW));
        check("wr_ready", 32'(wr_ready), 32'(exp_wr));
        m_acc = wr_valid && exp_wr;
        if (rd_req) begin
            e = '{1'b1, 1'b0, rd_addr, h_wdata};
            h_addr = rd_addr;
            rq.push_back('{cyc + 2, shadow[rd_addr]});
        end else if (m_acc) begin
            e = '{1'b1, 1'b1, wr_addr, wr_data};
            h_addr  = wr_addr;
            h_wdata = wr_data;
        end else begin
            e = '{1'b0, 1'b0, h_addr, h_wdata};
        end
        mq.push_back(e);
        @(posedge pix_clk);
        cyc++;
        m_tick = (m_st == 1) && (sx == 16'd0) && (int'(sy) == VH);
        if (sx == 16'd0) begin
            if (m_st == 0 && sy == 16'd0) m_st = 1;
            else if (m_st == 1 && int'(sy) == VH) m_st = 2;
            else if (m_st == 2 && sy == 16'd0) m_st = 1;
        end
        @(negedge pix_clk);
    endtask

    task automatic load_write();
        wr_valid = 1'b1;
        wr_addr  = wr_rand ? AW'($urandom_range(63)) : AW'(wr_seq);
        wr_data  = DW'($urandom_range(4095));
        wr_seq++;
    endtask

    task automatic do_reset(input int ncyc);
        pix_rstn = 1'b0;
        #1;
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_tick", 32'(frame_tick), 32'd0);
        check("rst_vblank", 32'(in_vblank), 32'd0);
        mq.delete();
        rq.delete();
        m_st    = 0;
        m_tick  = 1'b0;
        h_addr  = '0;
        h_wdata = '0;
        repeat (ncyc) @(negedge pix_clk);
        pix_rstn = 1'b1;
        mq.push_back('{1'b0, 1'b0, '0, '0});
    endtask

    // wmode: 0 idle, 1 always pending, 2 randomly pending
    // rmode: 0 none, 1 every active pixel, 2 random
    task automatic scan(input int y, input int x0, input int x1,
                        input int rmode, input int wmode);
        for (int x = x0; x <= x1; x++) begin
            sx = 16'(x);
            sy = 16'(y);
            case (rmode)
                1:       rd_req = (x < HW);
                2:       rd_req = (x < HW) ? ($urandom_range(1) == 1)
                                           : ($urandom_range(3) == 0);
                default: rd_req = 1'b0;
            endcase
            rd_addr = AW'($urandom_range(63));
            if (wmode == 0) wr_valid = 1'b0;
            else if (!wr_valid && $urandom_range(1) == 1) load_write();
            cycle();
            if (m_acc) begin
                if (acc_cnt == 0) begin
                    first_x = x;
                    first_y = y;
                end
                acc_cnt++;
                wr_valid = 1'b0;
                if (wmode == 1) load_write();
            end
        end
        rd_req = 1'b0;
    endtask

    initial begin
        int ticks0;
        n_chk = 0; n_fail = 0; cyc = 0;
        m_st = 0; m_tick = 1'b0; m_acc = 1'b0;
        h_addr = '0; h_wdata = '0;
        acc_cnt = 0; n_tick = 0; first_x = -1; first_y = -1;
        wr_rand = 1'b0; wr_seq = 16;
        for (int i = 0; i < (1 << AW); i++) begin
            vram[i]   = '0;
            shadow[i] = '0;
        end
        pix_rstn = 1'b0;
        sx = 16'd5; sy = 16'd10;
        rd_req = 1'b0; rd_addr = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        load_write();
        @(negedge pix_clk);

        // Reset released mid-frame: writer stalls until frame start
        do_reset(3);
        scan(10, 5, H_TOT - 1, 0, 1);
        check("sync_no_acc", 32'(acc_cnt), 32'd0);
        scan(0, 0, H_TOT - 1, 0, 1);
        check("first_acc_x", 32'(first_x), 32'd800);
        check("first_acc_y", 32'(first_y), 32'd0);
        check("line0_acc", 32'(acc_cnt), 32'(H_TOT - HW));

        // Reads every active pixel block the writer until hblank
        acc_cnt = 0; first_x = -1;
        scan(3, 0, H_TOT - 1, 1, 1);
        check("rd_line_first", 32'(first_x), 32'd800);
        check("rd_line_acc", 32'(acc_cnt), 32'(H_TOT - HW));

        // Vblank entry and a 100-write burst
        scan(479, 790, H_TOT - 1, 0, 0);
        ticks0 = n_tick;
        scan(VH, 0, 0, 0, 0);
        acc_cnt = 0; wr_seq = 256;
        load_write();
        scan(VH, 1, 100, 0, 1);
        check("vb_acc", 32'(acc_cnt), 32'd100);
        check("vb_ticks", 32'(n_tick - ticks0), 32'd1);
        check("vb_seq", 32'(wr_seq), 32'd357);

        // Read preempts vblank writer for exactly one cycle
        acc_cnt = 0;
        sx = 16'd101; sy = 16'(VH);
        rd_req = 1'b1; rd_addr = AW'(256 + 5);
        cycle();
        check("vb_rd_block", 32'(m_acc), 32'd0);
        rd_req = 1'b0; sx = 16'd102;
        cycle();
        check("vb_wr_after", 32'(m_acc), 32'd1);
        wr_valid = 1'b0;
        load_write();
        scan(VH, 103, 104, 0, 1);

        // Async reset mid-burst, then no tick without a frame start
        scan(VH, 105, 120, 0, 1);
        do_reset(2);
        ticks0 = n_tick; acc_cnt = 0;
        scan(VH - 1, 800, H_TOT - 1, 0, 1);
        scan(VH, 0, 40, 0, 1);
        check("post_rst_tick", 32'(n_tick - ticks0), 32'd0);
        check("post_rst_acc", 32'(acc_cnt), 32'd0);

        // Random stress over a compressed frame
        wr_rand = 1'b1;
        wr_valid = 1'b0;
        scan(0, 0, H_TOT - 1, 2, 2);
        scan(1, 0, H_TOT - 1, 2, 2);
        scan(200, 0, H_TOT - 1, 2, 2);
        scan(VH - 1, 0, H_TOT - 1, 2, 2);
        ticks0 = n_tick;
        scan(VH, 0, H_TOT - 1, 2, 2);
        scan(VH + 1, 0, H_TOT - 1, 2, 2);
        scan(0, 0, H_TOT - 1, 2, 2);
        wr_valid = 1'b0;
        scan(1, 0, 3, 0, 0);
        check("stress_ticks", 32'(n_tick - ticks0), 32'd1);
        check("rq_drained", 32'(rq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
